d_cache_nway: RTL and testbench

//  Parametrised write-through, no-write-allocate data cache between the riscv core MEM stage
//  and a word-wide backing data memory. Successor to the fixed single-line d_cache: adds

---
 rtl/d_cache_nway_pkg.sv | 17 +
 rtl/d_cache_nway_if.sv | 22 ++
 rtl/d_cache_nway_way.sv | 48 ++++
 rtl/d_cache_nway.sv | 225 ++++++++++++++++++++++
 tb/tb_d_cache_nway.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/d_cache_nway_pkg.sv
// Shared types and helpers for the n-way write-through data cache.
package d_cache_nway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/d_cache_nway_if.sv
// Word-wide request/acknowledge bus between the cache and backing memory.
interface d_cache_nway_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/d_cache_nway_way.sv
// One cache way: valid/tag/data storage, lookup and a single word write port.
module d_cache_nway_way #(
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 22,
  parameter int IDX_W       = 4,
  parameter int OFF_WS      = 2,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic [OFF_WS-1:0] off,
  output logic              hit,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_WS-1:0] wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  tag_val,
  input  logic              valid_val
);

  logic [SETS-1:0]   vld;
  logic [TAG_W-1:0]  tags [SETS];
  logic [DATA_W-1:0] data [SETS][BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (tag_we) begin
      vld[wr_idx] <= valid_val;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tags[wr_idx] <= tag_val;
    if (wr_en) data[wr_idx][wr_off] <= wr_data;
  end

  assign valid = vld[idx];
  assign hit   = valid && (tags[idx] == tag);
  assign rdata = data[idx][off];

endmodule

// File: rtl/d_cache_nway.sv
// Write-through, no-write-allocate set-associative data cache
// with LRU replacement, multi-word refill and core stall.
module d_cache_nway
  import d_cache_nway_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              ohit,
  output logic              stall,
  d_cache_nway_if.master    mem
);

  localparam int OFF_W  = clog2(BLOCK_WORDS);
  localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W  = clog2(SETS);
  localparam int TAG_W  = ADDR_W - 2 - IDX_W - OFF_W;
  localparam logic [OFF_WS-1:0] OFF_MASK =
    OFF_WS'(BLOCK_WORDS - 1);

  state_t state, state_n;

  logic [ADDR_W-3:0] wa;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF_WS-1:0] off;
  logic              unused_lsb;

  logic [WAYS-1:0]   hit_vec;
  logic [WAYS-1:0]   val_vec;
  logic [DATA_W-1:0] rdata_arr [WAYS];
  logic [DATA_W-1:0] hit_data;
  logic              any_hit;
  logic              hit_way;
  logic              victim_sel;

  logic [WAYS-1:0]   wr_en;
  logic [WAYS-1:0]   tag_we;
  logic [IDX_W-1:0]  wr_idx;
  logic [OFF_WS-1:0] wr_off;
  logic [DATA_W-1:0] wr_data;
  logic              valid_val;
  logic              fill_last;
  logic              fill_done;

  logic [OFF_WS-1:0] cnt;
  logic              victim;
  logic [TAG_W-1:0]  base_tag;
  logic [IDX_W-1:0]  base_idx;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] refill_addr;

  assign wa         = addra[ADDR_W-1:2];
  assign unused_lsb = ^addra[1:0];
  assign off        = OFF_WS'(wa) & OFF_MASK;
  assign idx        = IDX_W'(wa >> OFF_W);
  assign tag        = TAG_W'(wa >> (OFF_W + IDX_W));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    d_cache_nway_way #(
      .DATA_W      (DATA_W),
      .TAG_W       (TAG_W),
      .IDX_W       (IDX_W),
      .OFF_WS      (OFF_WS),
      .SETS        (SETS),
      .BLOCK_WORDS (BLOCK_WORDS)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx),
      .tag       (tag),
      .off       (off),
      .hit       (hit_vec[w]),
      .valid     (val_vec[w]),
      .rdata     (rdata_arr[w]),
      .wr_en     (wr_en[w]),
      .wr_idx    (wr_idx),
      .wr_off    (wr_off),
      .wr_data   (wr_data),
      .tag_we    (tag_we[w]),
      .tag_val   (base_tag),
      .valid_val (valid_val)
    );
  end

  assign any_hit = |hit_vec;

  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_data = hit_data | rdata_arr[w];
    end
  end

  // lru[i] names the way to evict next in set i
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru;

    assign hit_way    = hit_vec[1];
    assign victim_sel = !val_vec[0] ? 1'b0 :
                        !val_vec[1] ? 1'b1 : lru[idx];

    always_ff @(posedge clk) begin
      if (rst) begin
        lru <= '0;
      end else if (ohit) begin
        lru[idx] <= ~hit_way;
      end else if (fill_done) begin
        lru[base_idx] <= ~victim;
      end
    end
  end else begin : g_no_lru
    assign hit_way    = 1'b0;
    assign victim_sel = 1'b0;
  end

  assign fill_last = (cnt == OFF_MASK);

  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    ohit      = 1'b0;
    douta     = '0;
    wr_en     = '0;
    tag_we    = '0;
    wr_idx    = idx;
    wr_off    = off;
    wr_data   = dina;
    valid_val = 1'b0;
    fill_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (wea) begin
          stall   = 1'b1;
          wr_en   = hit_vec;
          state_n = ST_WRITE;
        end else if (ena) begin
          if (any_hit) begin
            ohit  = 1'b1;
            douta = hit_data;
          end else begin
            stall   = 1'b1;
            state_n = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        stall   = 1'b1;
        wr_idx  = base_idx;
        wr_off  = cnt;
        wr_data = mem.mem_rdata;
        if (mem.mem_ack) begin
          wr_en     = WAYS'(1) << victim;
          tag_we    = WAYS'(1) << victim;
          // line stays invalid until its last word lands
          valid_val = fill_last;
          if (fill_last) begin
            fill_done = 1'b1;
            state_n   = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        stall = !mem.mem_ack;
        if (mem.mem_ack) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      victim   <= 1'b0;
      base_tag <= '0;
      base_idx <= '0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        ST_IDLE: begin
          if (wea) begin
            waddr <= {wa, 2'b00};
            wdata <= dina;
          end else if (ena && !any_hit) begin
            base_tag <= tag;
            base_idx <= idx;
            victim   <= victim_sel;
            cnt      <= '0;
          end
        end
        ST_REFILL: begin
          if (mem.mem_ack) begin
            cnt <= fill_last ? '0 : cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign refill_addr =
    (ADDR_W'({base_tag, base_idx}) << (OFF_W + 2)) |
    (ADDR_W'(cnt) << 2);

  assign mem.mem_req   = (state != ST_IDLE);
  assign mem.mem_we    = (state == ST_WRITE);
  assign mem.mem_addr  = (state == ST_REFILL) ? refill_addr :
                         (state == ST_WRITE)  ? waddr : '0;
  assign mem.mem_wdata = (state == ST_WRITE) ? wdata : '0;

endmodule

// File: tb/tb_d_cache_nway.sv
// Directed bench for d_cache_nway with a two-cycle-latency
// backing memory model and transaction log.
module tb_d_cache_nway;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        wea;
  logic [31:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic        ohit;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int dly;

  logic        log_we   [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [31:0] mem_m [logic [31:0]];

  d_cache_nway_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  d_cache_nway dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .ohit  (ohit),
    .stall (stall),
    .mem   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return pat(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mif.mem_ack   <= 1'b0;
      mif.mem_rdata <= '0;
      dly = 0;
    end else begin
      mif.mem_ack <= 1'b0;
      if (mif.mem_req && !mif.mem_ack) begin
        if (dly == 1) begin
          dly = 0;
          mif.mem_ack <= 1'b1;
          log_we.push_back(mif.mem_we);
          log_addr.push_back(mif.mem_addr);
          if (mif.mem_we) begin
            mem_m[mif.mem_addr] = mif.mem_wdata;
            log_data.push_back(mif.mem_wdata);
          end else begin
            mif.mem_rdata <= rd_word(mif.mem_addr);
            log_data.push_back(rd_word(mif.mem_addr));
          end
        end else begin
          dly++;
        end
      end else begin
        dly = 0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic clr();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic access(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    wea   = w;
    ena   = !w;
    addra = a;
    dina  = d;
    #1;
  endtask

  task automatic drop();
    @(negedge clk);
    ena = 1'b0;
    wea = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 300), 32'd1);
  endtask

  task automatic chk_fill(input string tag,
                          input logic [31:0] base);
    chk({tag, "_n"}, 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < log_addr.size(); i++) begin
      chk({tag, "_we"}, 32'(log_we[i]), 32'd0);
      chk({tag, "_addr"}, log_addr[i], base + 32'(4 * i));
    end
  endtask

  initial begin
    rst   = 1'b1;
    ena   = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ohit", 32'(ohit), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_we", 32'(mif.mem_we), 32'd0);
    chk("rst_douta", douta, 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_wdata", mif.mem_wdata, 32'd0);
    rst = 1'b0;

    // cold read miss and refill
    clr();
    access(1'b0, 32'h100, 32'h0);
    chk("m100_stall", 32'(stall), 32'd1);
    chk("m100_ohit", 32'(ohit), 32'd0);
    wait_done("m100");
    chk("m100_ohit2", 32'(ohit), 32'd1);
    chk("m100_douta", douta, pat(32'h100));
    chk_fill("m100", 32'h100);
    drop();
    chk("idle_req", 32'(mif.mem_req), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);

    clr();
    access(1'b0, 32'h104, 32'h0);
    chk("h104_ohit", 32'(ohit), 32'd1);
    chk("h104_stall", 32'(stall), 32'd0);
    chk("h104_req", 32'(mif.mem_req), 32'd0);
    chk("h104_douta", douta, pat(32'h104));
    drop();
    chk("h104_nomem", 32'(log_addr.size()), 32'd0);

    // write hit goes through and updates the line
    clr();
    access(1'b1, 32'h108, 32'hDEADBEEF);
    chk("w108_stall", 32'(stall), 32'd1);
    wait_done("w108");
    chk("w108_ackwe", 32'(mif.mem_we), 32'd1);
    chk("w108_n", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      chk("w108_we", 32'(log_we[0]), 32'd1);
      chk("w108_addr", log_addr[0], 32'h108);
      chk("w108_data", log_data[0], 32'hDEADBEEF);
    end
    drop();
    access(1'b0, 32'h108, 32'h0);
    chk("r108_ohit", 32'(ohit), 32'd1);
    chk("r108_douta", douta, 32'hDEADBEEF);
    drop();

    // write miss does not allocate
    clr();
    access(1'b1, 32'h2000, 32'h55);
    wait_done("w2000");
    chk("w2000_n", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      chk("w2000_addr", log_addr[0], 32'h2000);
      chk("w2000_data", log_data[0], 32'h55);
    end
    drop();
    clr();
    access(1'b0, 32'h2000, 32'h0);
    chk("r2000_miss", 32'(stall), 32'd1);
    wait_done("r2000");
    chk("r2000_douta", douta, 32'h55);
    chk_fill("r2000", 32'h2000);
    drop();

    // LRU: set 5, tags A/B/C
    access(1'b0, 32'h1050, 32'h0);
    chk("lruA_miss", 32'(stall), 32'd1);
    wait_done("lruA");
    drop();
    access(1'b0, 32'h2050, 32'h0);
    chk("lruB_miss", 32'(stall), 32'd1);
    wait_done("lruB");
    chk("lruB_douta", douta, pat(32'h2050));
    drop();
    access(1'b0, 32'h1054, 32'h0);
    chk("lruA_hit", 32'(ohit), 32'd1);
    chk("lruA_douta", douta, pat(32'h1054));
    drop();
    clr();
    access(1'b0, 32'h3058, 32'h0);
    chk("lruC_miss", 32'(stall), 32'd1);
    wait_done("lruC");
    chk("lruC_douta", douta, pat(32'h3058));
    chk_fill("lruC", 32'h3050);
    drop();
    access(1'b0, 32'h1050, 32'h0);
    chk("lruA_kept", 32'(ohit), 32'd1);
    chk("lruA_kept_d", douta, pat(32'h1050));
    drop();
    access(1'b0, 32'h2050, 32'h0);
    chk("lruB_evicted", 32'(stall), 32'd1);
    wait_done("lruB2");
    chk("lruB2_douta", douta, pat(32'h2050));
    drop();

    // reset in the middle of a refill
    clr();
    access(1'b0, 32'h400, 32'h0);
    begin
      int n;
      n = 0;
      while (log_addr.size() < 2 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("rr_timeout", 32'(n < 300), 32'd1);
    end
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    #1;
    chk("rr_req", 32'(mif.mem_req), 32'd0);
    chk("rr_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clr();
    access(1'b0, 32'h2000, 32'h0);
    chk("rr_inval", 32'(stall), 32'd1);
    wait_done("rr2000");
    chk("rr2000_douta", douta, 32'h55);
    chk_fill("rr2000", 32'h2000);
    drop();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

endmodule
